// File: rtl/imem_program_loader.sv
// Boot-time instruction-memory loader: packs a little-endian byte stream into 32-bit words,
// writes them from word address 0 and holds the core in reset until loading is done.
// Optional build macro LOADER_CHECKSUM_EN: the s_last byte is a checksum; a bad sum parks the FSM in FAIL.
module imem_program_loader #(
    parameter int ADDR_W        = 8,
    parameter int RELEASE_DELAY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_partial,
    output logic              err_overflow,
    output logic              err_checksum
);

    // state | meaning
    // LOAD  | accepting stream bytes into the current word
    // WRITE | one-cycle imem write of the assembled word (suppressed when full)
    // HOLD  | program loaded, core still in reset for RELEASE_DELAY cycles
    // RUN   | core released, loader idle until reset
    // FAIL  | checksum mismatch, core kept in reset (checksum build only)

    localparam int CNT_W     = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY + 1) : 1;
    localparam int HOLD_INIT = (RELEASE_DELAY > 0) ? RELEASE_DELAY - 1 : 0;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_WRITE,
        ST_HOLD,
`ifdef LOADER_CHECKSUM_EN
        ST_FAIL,
`endif
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         lane_q, lane_d;
    logic [31:0]        word_q, word_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]    wc_q, wc_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               perr_q, perr_d;
    logic               oerr_q, oerr_d;
    logic [31:0]        asm_word;
    logic [31:0]        complete_word;
    logic               complete;
    logic               full;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
    logic               cerr_q, cerr_d;
`endif

    // Counter saturates at 2^ADDR_W, so its MSB alone flags a full memory.
    assign full = wc_q[ADDR_W];

    always_comb begin
        asm_word = word_q;
        asm_word[{lane_q, 3'b000} +: 8] = s_data;
    end

    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        word_d        = word_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        wc_d          = wc_q;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        perr_d        = perr_q;
        oerr_d        = oerr_q;
        complete      = 1'b0;
        complete_word = asm_word;
`ifdef LOADER_CHECKSUM_EN
        sum_d         = sum_q;
        cerr_d        = cerr_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (s_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + s_data;
                    if (s_last) begin
                        if (sum_d != 8'h00) cerr_d = 1'b1;
                        if (lane_q != 2'd0) begin
                            complete      = 1'b1;
                            complete_word = word_q;
                            last_d        = 1'b1;
                            perr_d        = 1'b1;
                        end else if (sum_d != 8'h00) begin
                            state_d = ST_FAIL;
                        end else if (RELEASE_DELAY == 0) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_HOLD;
                            cnt_d   = CNT_W'(HOLD_INIT);
                        end
                    end else if (lane_q == 2'd3) begin
                        complete = 1'b1;
                        last_d   = 1'b0;
                    end else begin
                        word_d = asm_word;
                        lane_d = lane_q + 2'd1;
                    end
`else
                    if (s_last || lane_q == 2'd3) begin
                        complete = 1'b1;
                        last_d   = s_last;
                        if (lane_q != 2'd3) perr_d = 1'b1;
                    end else begin
                        word_d = asm_word;
                        lane_d = lane_q + 2'd1;
                    end
`endif
                end
                if (complete) begin
                    state_d = ST_WRITE;
                    lane_d  = 2'd0;
                    word_d  = '0;
                    if (!full) begin
                        waddr_d = wc_q[ADDR_W-1:0];
                        wdata_d = complete_word;
                    end
                end
            end
            ST_WRITE: begin
                if (full) oerr_d = 1'b1;
                else      wc_d   = wc_q + {{ADDR_W{1'b0}}, 1'b1};
                if (!last_q) begin
                    state_d = ST_LOAD;
`ifdef LOADER_CHECKSUM_EN
                end else if (cerr_q) begin
                    state_d = ST_FAIL;
`endif
                end else if (RELEASE_DELAY == 0) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(HOLD_INIT);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_d = ST_RUN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RUN: state_d = ST_RUN;
`ifdef LOADER_CHECKSUM_EN
            ST_FAIL: state_d = ST_FAIL;
`endif
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_LOAD;
            lane_q  <= 2'd0;
            word_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            wc_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            perr_q  <= 1'b0;
            oerr_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
            cerr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            wc_q    <= wc_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            perr_q  <= perr_d;
            oerr_q  <= oerr_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
            cerr_q  <= cerr_d;
`endif
        end
    end

    assign s_ready      = (state_q == ST_LOAD);
    assign imem_we      = (state_q == ST_WRITE) && !full;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign core_reset   = (state_q != ST_RUN);
    assign load_done    = (state_q == ST_RUN);
    assign word_count   = wc_q;
    assign err_partial  = perr_q;
    assign err_overflow = oerr_q;
`ifdef LOADER_CHECKSUM_EN
    assign err_checksum = cerr_q;
`else
    assign err_checksum = 1'b0;
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: directed programs plus randomized streams against a word-list model.
// Instance A uses default parameters; instance B (ADDR_W=2, RELEASE_DELAY=0) covers overflow.
module tb_imem_program_loader;

    localparam int AW_A = 8;
    localparam int RD_A = 2;
    localparam int AW_B = 2;
    localparam int RD_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;
    logic       sel   = 1'b0;
    logic       v     = 1'b0;
    logic       last  = 1'b0;
    logic [7:0] data  = 8'h00;

    logic             s_valid_a, s_ready_a, we_a, crst_a, done_a, perr_a, oerr_a, cerr_a;
    logic [AW_A-1:0]  waddr_a;
    logic [31:0]      wdata_a;
    logic [AW_A:0]    wc_a;
    logic             s_valid_b, s_ready_b, we_b, crst_b, done_b, perr_b, oerr_b, cerr_b;
    logic [AW_B-1:0]  waddr_b;
    logic [31:0]      wdata_b;
    logic [AW_B:0]    wc_b;

    assign s_valid_a = v & ~sel;
    assign s_valid_b = v & sel;

    imem_program_loader #(.ADDR_W(AW_A), .RELEASE_DELAY(RD_A)) u_dut_a (
        .clk(clk), .reset(reset), .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(data),
        .s_last(last), .imem_we(we_a), .imem_waddr(waddr_a), .imem_wdata(wdata_a),
        .core_reset(crst_a), .load_done(done_a), .word_count(wc_a), .err_partial(perr_a),
        .err_overflow(oerr_a), .err_checksum(cerr_a)
    );

    imem_program_loader #(.ADDR_W(AW_B), .RELEASE_DELAY(RD_B)) u_dut_b (
        .clk(clk), .reset(reset), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(data),
        .s_last(last), .imem_we(we_b), .imem_waddr(waddr_b), .imem_wdata(wdata_b),
        .core_reset(crst_b), .load_done(done_b), .word_count(wc_b), .err_partial(perr_b),
        .err_overflow(oerr_b), .err_checksum(cerr_b)
    );

    // View of whichever instance is currently selected.
    logic        ready_v, we_v, crst_v, done_v, perr_v, oerr_v, cerr_v;
    logic [7:0]  waddr_v;
    logic [31:0] wdata_v;
    logic [8:0]  wc_v;
    assign ready_v = sel ? s_ready_b : s_ready_a;
    assign we_v    = sel ? we_b : we_a;
    assign crst_v  = sel ? crst_b : crst_a;
    assign done_v  = sel ? done_b : done_a;
    assign perr_v  = sel ? perr_b : perr_a;
    assign oerr_v  = sel ? oerr_b : oerr_a;
    assign cerr_v  = sel ? cerr_b : cerr_a;
    assign waddr_v = sel ? {6'b0, waddr_b} : waddr_a;
    assign wdata_v = sel ? wdata_b : wdata_a;
    assign wc_v    = sel ? {6'b0, wc_b} : wc_a;

    typedef struct { int addr; logic [31:0] data; int nhs; int lat; } wr_t;
    typedef struct { int addr; logic [31:0] data; } exp_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    wr_t  wq[$];
    int   hs_cnt, last_hs_cyc, ready_in_write, total_hs, last_we_cyc, rel_cyc;
    logic [7:0] prog[$];

    exp_t exp_q[$];
    int   exp_wc;
    bit   exp_perr, exp_oerr, exp_cerr, exp_rel;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we_v) begin
            wr_t w;
            w.addr = int'(waddr_v);
            w.data = wdata_v;
            w.nhs  = hs_cnt;
            w.lat  = cyc - last_hs_cyc;
            wq.push_back(w);
            hs_cnt = 0;
            last_we_cyc = cyc;
            if (ready_v) ready_in_write++;
        end
        if (reset && v && ready_v) begin
            hs_cnt++;
            total_hs++;
            last_hs_cyc = cyc;
        end
        if (reset && !crst_v && rel_cyc < 0) rel_cyc = cyc;
    end

    task automatic clear_mon();
        wq.delete();
        hs_cnt = 0;
        last_hs_cyc = 0;
        ready_in_write = 0;
        total_hs = 0;
        last_we_cyc = -1;
        rel_cyc = -1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        v = 1'b0; last = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        clear_mon();
    endtask

    task automatic send(input bit hold, input bit mark_last);
        int budget;
        for (int i = 0; i < prog.size(); i++) begin
            if (!hold && $urandom_range(0, 2) == 0) begin
                v = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            v = 1'b1;
            data = prog[i];
            last = mark_last && (i == prog.size() - 1);
            budget = 0;
            while (!ready_v && budget < 100) begin
                @(posedge clk); #1;
                budget++;
            end
            if (!ready_v) begin
                vectors++; miscompares++;
                $display("FAIL handshake_timeout: byte %0d waited %0d cycles, required acceptance", i, budget);
                v = 1'b0; last = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        v = 1'b0; last = 1'b0;
    endtask

    task automatic settle();
        repeat (60) @(posedge clk);
        #1;
    endtask

    // Reference: split data bytes into zero-padded LE words, drop words beyond capacity.
    task automatic model(input int aw);
        int n, nw, cap, s;
        logic [31:0] w;
        exp_t e;
        n = prog.size();
`ifdef LOADER_CHECKSUM_EN
        n = n - 1;
`endif
        nw = (n + 3) / 4;
        cap = 1 << aw;
        exp_q.delete();
        for (int wi = 0; wi < nw; wi++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++)
                if (4 * wi + k < n) w[8 * k +: 8] = prog[4 * wi + k];
            if (wi < cap) begin
                e.addr = wi; e.data = w;
                exp_q.push_back(e);
            end
        end
        exp_wc = (nw < cap) ? nw : cap;
        exp_perr = (n % 4) != 0;
        exp_oerr = nw > cap;
        s = 0;
        foreach (prog[i]) s += int'(prog[i]);
`ifdef LOADER_CHECKSUM_EN
        exp_cerr = (s % 256) != 0;
`else
        exp_cerr = 1'b0;
`endif
        exp_rel = !exp_cerr;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            vectors++; if (ready_v !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready[%0d]: got %b want 1", s, ready_v); end
            vectors++; if (we_v !== 1'b0) begin miscompares++; $display("FAIL reset_imem_we[%0d]: got %b want 0", s, we_v); end
            vectors++; if (waddr_v !== 8'h0) begin miscompares++; $display("FAIL reset_waddr[%0d]: got %h want 0", s, waddr_v); end
            vectors++; if (wdata_v !== 32'h0) begin miscompares++; $display("FAIL reset_wdata[%0d]: got %h want 0", s, wdata_v); end
            vectors++; if (crst_v !== 1'b1) begin miscompares++; $display("FAIL reset_core_reset[%0d]: got %b want 1", s, crst_v); end
            vectors++; if (done_v !== 1'b0) begin miscompares++; $display("FAIL reset_load_done[%0d]: got %b want 0", s, done_v); end
            vectors++; if (wc_v !== 9'd0) begin miscompares++; $display("FAIL reset_word_count[%0d]: got %0d want 0", s, wc_v); end
            vectors++; if ({perr_v, oerr_v, cerr_v} !== 3'b000) begin miscompares++; $display("FAIL reset_errs[%0d]: got %b want 000", s, {perr_v, oerr_v, cerr_v}); end
        end
        sel = 1'b0;
    endtask

`ifndef LOADER_CHECKSUM_EN
    task automatic test_plan_program();
        sel = 1'b0;
        do_reset();
        prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        send(1'b1, 1'b1);
        settle();
        vectors++;
        if (wq.size() !== 2) begin miscompares++; $display("FAIL plan_nwrites: got %0d want 2", wq.size()); end
        else begin
            vectors++; if (wq[0].addr !== 0 || wq[0].data !== 32'h00500513) begin miscompares++; $display("FAIL plan_w0: got %0d/%h want 0/00500513", wq[0].addr, wq[0].data); end
            vectors++; if (wq[1].addr !== 1 || wq[1].data !== 32'h00A00593) begin miscompares++; $display("FAIL plan_w1: got %0d/%h want 1/00a00593", wq[1].addr, wq[1].data); end
        end
        vectors++; if (wc_v !== 9'd2) begin miscompares++; $display("FAIL plan_word_count: got %0d want 2", wc_v); end
        vectors++; if (rel_cyc - last_we_cyc !== RD_A + 1) begin miscompares++; $display("FAIL plan_release_delay: got %0d want %0d", rel_cyc - last_we_cyc, RD_A + 1); end
        vectors++; if (done_v !== 1'b1 || crst_v !== 1'b0) begin miscompares++; $display("FAIL plan_released: got done=%b crst=%b want 1/0", done_v, crst_v); end
        vectors++; if (perr_v !== 1'b0) begin miscompares++; $display("FAIL plan_err_partial: got %b want 0", perr_v); end
    endtask

    task automatic test_partial();
        sel = 1'b0;
        do_reset();
        prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        send(1'b0, 1'b1);
        settle();
        vectors++;
        if (wq.size() !== 2) begin miscompares++; $display("FAIL partial_nwrites: got %0d want 2", wq.size()); end
        else begin
            vectors++; if (wq[0].data !== 32'hDDCCBBAA) begin miscompares++; $display("FAIL partial_w0: got %h want ddccbbaa", wq[0].data); end
            vectors++; if (wq[1].addr !== 1 || wq[1].data !== 32'h00002211) begin miscompares++; $display("FAIL partial_w1: got %0d/%h want 1/00002211", wq[1].addr, wq[1].data); end
        end
        vectors++; if (perr_v !== 1'b1) begin miscompares++; $display("FAIL partial_err: got %b want 1", perr_v); end
        vectors++; if (done_v !== 1'b1) begin miscompares++; $display("FAIL partial_released: got %b want 1", done_v); end
    endtask
`else
    task automatic test_checksum();
        sel = 1'b0;
        do_reset();
        prog = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
        send(1'b0, 1'b1);
        settle();
        vectors++;
        if (wq.size() !== 1) begin miscompares++; $display("FAIL csum_ok_nwrites: got %0d want 1", wq.size()); end
        else begin
            vectors++; if (wq[0].addr !== 0 || wq[0].data !== 32'h00000001) begin miscompares++; $display("FAIL csum_ok_w0: got %0d/%h want 0/00000001", wq[0].addr, wq[0].data); end
        end
        vectors++; if (done_v !== 1'b1 || cerr_v !== 1'b0) begin miscompares++; $display("FAIL csum_ok_release: got done=%b cerr=%b want 1/0", done_v, cerr_v); end
        do_reset();
        prog = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        send(1'b0, 1'b1);
        settle();
        vectors++; if (cerr_v !== 1'b1) begin miscompares++; $display("FAIL csum_bad_err: got %b want 1", cerr_v); end
        vectors++; if (crst_v !== 1'b1 || done_v !== 1'b0) begin miscompares++; $display("FAIL csum_bad_hold: got crst=%b done=%b want 1/0", crst_v, done_v); end
        vectors++; if (ready_v !== 1'b0) begin miscompares++; $display("FAIL csum_bad_ready: got %b want 0", ready_v); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] s;
        sel = 1'b0;
        do_reset();
        prog.delete();
        s = 8'h00;
        for (int i = 0; i < 16; i++) begin
            prog.push_back(8'($urandom_range(0, 255)));
            s = s + prog[i];
        end
`ifdef LOADER_CHECKSUM_EN
        prog.push_back(8'h00 - s);
`endif
        model(AW_A);
        send(1'b1, 1'b1);
        settle();
        vectors++;
        if (wq.size() !== exp_q.size()) begin miscompares++; $display("FAIL b2b_nwrites: got %0d want %0d", wq.size(), exp_q.size()); end
        else foreach (wq[i]) begin
            vectors++; if (wq[i].data !== exp_q[i].data) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", i, wq[i].data, exp_q[i].data); end
            vectors++; if (wq[i].nhs !== 4) begin miscompares++; $display("FAIL b2b_handshakes[%0d]: got %0d want 4", i, wq[i].nhs); end
            vectors++; if (wq[i].lat !== 1) begin miscompares++; $display("FAIL b2b_latency[%0d]: got %0d want 1", i, wq[i].lat); end
        end
        vectors++; if (ready_in_write !== 0) begin miscompares++; $display("FAIL b2b_ready_in_write: got %0d want 0", ready_in_write); end
        vectors++; if (total_hs !== prog.size()) begin miscompares++; $display("FAIL b2b_total_handshakes: got %0d want %0d", total_hs, prog.size()); end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        do_reset();
        prog = '{8'hDE, 8'hAD, 8'hBE};
        send(1'b0, 1'b0);
        do_reset();
`ifdef LOADER_CHECKSUM_EN
        prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
`else
        prog = '{8'h01, 8'h02, 8'h03, 8'h04};
`endif
        send(1'b0, 1'b1);
        settle();
        vectors++;
        if (wq.size() !== 1) begin miscompares++; $display("FAIL midreset_nwrites: got %0d want 1", wq.size()); end
        else begin
            vectors++; if (wq[0].addr !== 0 || wq[0].data !== 32'h04030201) begin miscompares++; $display("FAIL midreset_w0: got %0d/%h want 0/04030201", wq[0].addr, wq[0].data); end
        end
        vectors++; if ({perr_v, oerr_v, cerr_v} !== 3'b000) begin miscompares++; $display("FAIL midreset_errs: got %b want 000", {perr_v, oerr_v, cerr_v}); end
        vectors++; if (wc_v !== 9'd1) begin miscompares++; $display("FAIL midreset_word_count: got %0d want 1", wc_v); end
    endtask

    task automatic test_overflow();
        sel = 1'b1;
        do_reset();
        prog.delete();
        for (int i = 0; i < 20; i++) prog.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] s = 8'h00;
            foreach (prog[i]) s = s + prog[i];
            prog.push_back(8'h00 - s);
        end
`endif
        model(AW_B);
        send(1'b0, 1'b1);
        settle();
        vectors++;
        if (wq.size() !== 4) begin miscompares++; $display("FAIL ovf_nwrites: got %0d want 4", wq.size()); end
        else foreach (wq[i]) begin
            vectors++; if (wq[i].addr !== exp_q[i].addr || wq[i].data !== exp_q[i].data) begin miscompares++; $display("FAIL ovf_w[%0d]: got %0d/%h want %0d/%h", i, wq[i].addr, wq[i].data, exp_q[i].addr, exp_q[i].data); end
        end
        vectors++; if (oerr_v !== 1'b1) begin miscompares++; $display("FAIL ovf_err: got %b want 1", oerr_v); end
        vectors++; if (wc_v !== 9'd4) begin miscompares++; $display("FAIL ovf_word_count: got %0d want 4", wc_v); end
        vectors++; if (done_v !== 1'b1) begin miscompares++; $display("FAIL ovf_released: got %b want 1", done_v); end
        sel = 1'b0;
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 10; it++) begin
            sel = it[0];
            do_reset();
            len = sel ? $urandom_range(1, 24) : $urandom_range(1, 30);
            prog.delete();
            for (int i = 0; i < len; i++) prog.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
            if ($urandom_range(0, 1) == 1) begin
                logic [7:0] s = 8'h00;
                foreach (prog[i]) s = s + prog[i];
                prog.push_back(8'h00 - s);
            end else begin
                prog.push_back(8'($urandom_range(0, 255)));
            end
`endif
            model(sel ? AW_B : AW_A);
            send(1'b0, 1'b1);
            settle();
            vectors++;
            if (wq.size() !== exp_q.size()) begin
                miscompares++; $display("FAIL rand%0d_nwrites: got %0d want %0d", it, wq.size(), exp_q.size());
            end else foreach (wq[i]) begin
                vectors++;
                if (wq[i].addr !== exp_q[i].addr || wq[i].data !== exp_q[i].data) begin
                    miscompares++;
                    $display("FAIL rand%0d_w[%0d]: got %0d/%h want %0d/%h", it, i, wq[i].addr, wq[i].data, exp_q[i].addr, exp_q[i].data);
                end
            end
            vectors++; if (wc_v !== 9'(exp_wc)) begin miscompares++; $display("FAIL rand%0d_word_count: got %0d want %0d", it, wc_v, exp_wc); end
            vectors++;
            if ({perr_v, oerr_v, cerr_v} !== {exp_perr, exp_oerr, exp_cerr}) begin
                miscompares++; $display("FAIL rand%0d_errs: got %b want %b", it, {perr_v, oerr_v, cerr_v}, {exp_perr, exp_oerr, exp_cerr});
            end
            vectors++;
            if (done_v !== exp_rel || crst_v !== !exp_rel) begin
                miscompares++; $display("FAIL rand%0d_release: got done=%b crst=%b want done=%b", it, done_v, crst_v, exp_rel);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        clear_mon();
        test_reset();
`ifndef LOADER_CHECKSUM_EN
        test_plan_program();
        test_partial();
`else
        test_checksum();
`endif
        test_back_to_back();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
